// File: rtl/gg_pack_pkg.sv
// Shared types and constants for the CAVLC bit packer.
package gg_pack_pkg;

  localparam int ACC_WIDTH = 64;
  localparam int OUT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } pack_state_e;

endpackage

// File: rtl/gg_bit_append.sv
// Combinational append of up to 32 left-justified bits into the accumulator.
module gg_bit_append
  import gg_pack_pkg::*;
(
  input  logic [ACC_WIDTH-1:0] acc,
  input  logic [5:0]           acc_cnt,
  input  logic [OUT_WIDTH-1:0] hold_top,
  input  logic [5:0]           n,
  output logic [ACC_WIDTH-1:0] acc_new,
  output logic [5:0]           acc_cnt_new
);

  logic [OUT_WIDTH-1:0] keep_mask;
  logic [ACC_WIDTH-1:0] ins;

  // Mask off don't-care bits below n, then place the chunk just after the valid bits.
  always_comb begin
    keep_mask   = ~({OUT_WIDTH{1'b1}} >> n);
    ins         = {hold_top & keep_mask, {(ACC_WIDTH-OUT_WIDTH){1'b0}}} >> acc_cnt;
    acc_new     = acc | ins;
    acc_cnt_new = acc_cnt + n;
  end

endmodule

// File: rtl/gg_bit_packer.sv
// Packs variable-length coded blocks MSB-first into a 32-bit word stream.
//
// state | meaning
// IDLE  | ready for a data or flush beat
// DRAIN | moving the held block into the accumulator, up to 32 bits per cycle
// FLUSH | emitting remaining full words, then the padded last word
module gg_bit_packer #(
  parameter int IN_WIDTH  = 512,
  parameter int CNT_WIDTH = 9,
  parameter int OUT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_bits,
  input  logic [CNT_WIDTH-1:0] in_bitcount,
  input  logic                 in_flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_word,
  output logic [2:0]           out_bytes,
  output logic                 out_last,
  output logic                 flush_done,
  output logic [31:0]          bit_total
);

  import gg_pack_pkg::*;

  pack_state_e            state_q, state_d;
  logic [IN_WIDTH-1:0]    hold_q, hold_d;
  logic [CNT_WIDTH-1:0]   rem_q, rem_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d, acc_e, acc_a;
  logic [5:0]             acc_cnt_q, acc_cnt_d, cnt_e, cnt_a;
  logic                   out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0]   out_word_q, out_word_d;
  logic [2:0]             out_bytes_q, out_bytes_d;
  logic                   out_last_q, out_last_d;
  logic                   flush_done_q, flush_done_d;
  logic [31:0]            bit_total_q, bit_total_d;
  logic                   out_free;
  logic [5:0]             n;

  gg_bit_append u_append (
    .acc         (acc_e),
    .acc_cnt     (cnt_e),
    .hold_top    (hold_q[IN_WIDTH-1 -: OUT_WIDTH]),
    .n           (n),
    .acc_new     (acc_a),
    .acc_cnt_new (cnt_a)
  );

  // Accept, then emit, then append against the post-emit accumulator.
  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    rem_d        = rem_q;
    out_valid_d  = out_valid_q;
    out_word_d   = out_word_q;
    out_bytes_d  = out_bytes_q;
    out_last_d   = out_last_q;
    flush_done_d = 1'b0;
    bit_total_d  = bit_total_q;
    out_free     = !out_valid_q || out_ready;
    acc_e        = acc_q;
    cnt_e        = acc_cnt_q;
    n            = (rem_q >= CNT_WIDTH'(32)) ? 6'd32 : rem_q[5:0];

    if (state_q == IDLE && in_valid) begin
      if (in_flush) begin
        state_d = FLUSH;
      end else begin
        hold_d      = in_bits;
        rem_d       = in_bitcount;
        bit_total_d = bit_total_q + 32'(in_bitcount);
        if (in_bitcount != '0) state_d = DRAIN;
      end
    end

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (out_free && acc_cnt_q[5]) begin
      out_word_d  = acc_q[ACC_WIDTH-1 -: OUT_WIDTH];
      out_bytes_d = 3'd4;
      out_last_d  = 1'b0;
      out_valid_d = 1'b1;
      acc_e       = acc_q << OUT_WIDTH;
      cnt_e       = acc_cnt_q - 6'd32;
    end else if (out_free && state_q == FLUSH) begin
      flush_done_d = 1'b1;
      state_d      = IDLE;
      if (acc_cnt_q != 6'd0) begin
        out_word_d  = acc_q[ACC_WIDTH-1 -: OUT_WIDTH] & ~({OUT_WIDTH{1'b1}} >> acc_cnt_q[4:0]);
        out_bytes_d = 3'((acc_cnt_q + 6'd7) >> 3);
        out_last_d  = 1'b1;
        out_valid_d = 1'b1;
        acc_e       = '0;
        cnt_e       = 6'd0;
      end
    end

    acc_d     = acc_e;
    acc_cnt_d = cnt_e;
    if (state_q == DRAIN && !cnt_e[5]) begin
      acc_d     = acc_a;
      acc_cnt_d = cnt_a;
      hold_d    = hold_q << n;
      rem_d     = rem_q - CNT_WIDTH'(n);
      if (rem_d == '0) state_d = IDLE;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      rem_q        <= '0;
      acc_q        <= '0;
      acc_cnt_q    <= '0;
      out_valid_q  <= 1'b0;
      out_word_q   <= '0;
      out_bytes_q  <= '0;
      out_last_q   <= 1'b0;
      flush_done_q <= 1'b0;
      bit_total_q  <= '0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      rem_q        <= rem_d;
      acc_q        <= acc_d;
      acc_cnt_q    <= acc_cnt_d;
      out_valid_q  <= out_valid_d;
      out_word_q   <= out_word_d;
      out_bytes_q  <= out_bytes_d;
      out_last_q   <= out_last_d;
      flush_done_q <= flush_done_d;
      bit_total_q  <= bit_total_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = out_valid_q;
  assign out_word   = out_word_q;
  assign out_bytes  = out_bytes_q;
  assign out_last   = out_last_q;
  assign flush_done = flush_done_q;
  assign bit_total  = bit_total_q;

endmodule

// File: tb/tb_gg_bit_packer.sv
// Directed bench for gg_bit_packer.
module tb_gg_bit_packer;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [511:0] in_bits;
  logic [8:0]   in_bitcount;
  logic         in_flush;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_word;
  logic [2:0]   out_bytes;
  logic         out_last;
  logic         flush_done;
  logic [31:0]  bit_total;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int fd_count = 0;
  int fd_cyc   = 0;
  logic fd_word = 1'b0;

  logic [31:0] wq[$];
  logic [2:0]  bq[$];
  logic        lq[$];
  int          cq[$];

  gg_bit_packer dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_bits     (in_bits),
    .in_bitcount (in_bitcount),
    .in_flush    (in_flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_word    (out_word),
    .out_bytes   (out_bytes),
    .out_last    (out_last),
    .flush_done  (flush_done),
    .bit_total   (bit_total)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every consumed word and every flush_done pulse.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      wq.push_back(out_word);
      bq.push_back(out_bytes);
      lq.push_back(out_last);
      cq.push_back(cyc);
    end
    if (flush_done) begin
      fd_count = fd_count + 1;
      fd_word  = out_valid && out_last;
      fd_cyc   = cyc;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_q();
    wq.delete(); bq.delete(); lq.delete(); cq.delete();
  endtask

  task automatic tick(input int k);
    repeat (k) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [511:0] b, input logic [8:0] c, input logic f,
                      input bit keep, output int acc_cyc);
    bit ok;
    ok = 1'b0;
    acc_cyc = -1;
    in_valid = 1'b1; in_bits = b; in_bitcount = c; in_flush = f;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (ok) begin
      @(posedge clk); #1;
      acc_cyc = cyc;
    end
    check("accept", 64'(ok), 64'd1);
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_fd(input string tag, input int target);
    for (int i = 0; i < 300; i++) begin
      if (fd_count >= target) break;
      tick(1);
    end
    check(tag, 64'(fd_count), 64'(target));
  endtask

  task automatic wait_words(input string tag, input int target);
    for (int i = 0; i < 300; i++) begin
      if (wq.size() >= target) break;
      tick(1);
    end
    check(tag, 64'(wq.size()), 64'(target));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"},   64'(in_ready),   64'd1);
    check({tag, "_out_valid"},  64'(out_valid),  64'd0);
    check({tag, "_out_word"},   64'(out_word),   64'd0);
    check({tag, "_out_bytes"},  64'(out_bytes),  64'd0);
    check({tag, "_out_last"},   64'(out_last),   64'd0);
    check({tag, "_flush_done"}, 64'(flush_done), 64'd0);
    check({tag, "_bit_total"},  64'(bit_total),  64'd0);
  endtask

  // 15 words of ones followed by the 21-bit padded tail.
  task automatic check_501_stream(input string tag);
    int bad;
    bad = 0;
    check({tag, "_count"}, 64'(wq.size()), 64'd16);
    if (wq.size() == 16) begin
      for (int i = 0; i < 15; i++)
        if (wq[i] !== 32'hFFFFFFFF || bq[i] !== 3'd4 || lq[i] !== 1'b0) bad++;
      check({tag, "_full_words"}, 64'(bad), 64'd0);
      check({tag, "_tail_word"},  64'(wq[15]), 64'hFFFFF800);
      check({tag, "_tail_bytes"}, 64'(bq[15]), 64'd3);
      check({tag, "_tail_last"},  64'(lq[15]), 64'd1);
    end
  endtask

  initial begin
    int a1, a2, a3, fd_exp, unstable, inr;
    logic [31:0] held;
    fd_exp = 0;
    reset = 1'b1; in_valid = 1'b0; in_bits = '0; in_bitcount = '0; in_flush = 1'b0;
    out_ready = 1'b1;
    tick(2);
    check_reset_vals("rst_hold");
    reset = 1'b0;
    tick(1);
    check_reset_vals("rst_rel");

    // 5-bit block with garbage below the count, then flush
    send({5'b10110, {507{1'b1}}}, 9'd5, 1'b0, 1'b0, a1);
    send('0, 9'd0, 1'b1, 1'b0, a2);
    fd_exp++;
    wait_fd("t5_fd", fd_exp);
    check("t5_count", 64'(wq.size()), 64'd1);
    if (wq.size() == 1) begin
      check("t5_word",  64'(wq[0]), 64'hB0000000);
      check("t5_bytes", 64'(bq[0]), 64'd1);
      check("t5_last",  64'(lq[0]), 64'd1);
      check("t5_fd_same_cycle", 64'(fd_cyc), 64'(cq[0]));
    end
    check("t5_fd_word", 64'(fd_word), 64'd1);
    check("t5_bit_total", 64'(bit_total), 64'd5);
    tick(2);
    check("t5_fd_pulse", 64'(flush_done), 64'd0);
    clear_q();

    // 20 bits + 12 bits make exactly one word; flush yields none
    send({20'hABCDE, 492'd0}, 9'd20, 1'b0, 1'b0, a1);
    send({12'h123, 500'd0}, 9'd12, 1'b0, 1'b0, a1);
    tick(5);
    check("t32_count", 64'(wq.size()), 64'd1);
    if (wq.size() == 1) begin
      check("t32_word",  64'(wq[0]), 64'hABCDE123);
      check("t32_bytes", 64'(bq[0]), 64'd4);
      check("t32_last",  64'(lq[0]), 64'd0);
    end
    check("t32_bit_total", 64'(bit_total), 64'd37);
    send('0, 9'd0, 1'b1, 1'b0, a1);
    fd_exp++;
    wait_fd("t32_fd", fd_exp);
    check("t32_fd_no_word", 64'(fd_word), 64'd0);
    check("t32_count_after", 64'(wq.size()), 64'd1);
    clear_q();

    // 501 ones, no backpressure
    send({512{1'b1}}, 9'd501, 1'b0, 1'b0, a1);
    wait_words("t501_words", 15);
    if (wq.size() >= 15) begin
      check("t501_first_latency", 64'(cq[0]), 64'(a1 + 2));
      check("t501_consecutive",   64'(cq[14] - cq[0]), 64'd14);
    end
    send('0, 9'd0, 1'b1, 1'b0, a2);
    fd_exp++;
    wait_fd("t501_fd", fd_exp);
    check_501_stream("t501");
    check("t501_bit_total", 64'(bit_total), 64'd538);
    clear_q();

    // Same block with a 20-cycle stall
    send({512{1'b1}}, 9'd501, 1'b0, 1'b0, a1);
    tick(2);
    out_ready = 1'b0;
    check("stall_valid", 64'(out_valid), 64'd1);
    held = out_word;
    unstable = 0; inr = 0;
    repeat (20) begin
      tick(1);
      if (out_word !== held || out_valid !== 1'b1) unstable++;
      if (in_ready !== 1'b0) inr++;
    end
    check("stall_word_stable", 64'(unstable), 64'd0);
    check("stall_in_ready_low", 64'(inr), 64'd0);
    check("stall_no_consume", 64'(wq.size()), 64'd0);
    out_ready = 1'b1;
    wait_words("stall_words", 15);
    send('0, 9'd0, 1'b1, 1'b0, a2);
    fd_exp++;
    wait_fd("stall_fd", fd_exp);
    check_501_stream("stall");
    check("stall_bit_total", 64'(bit_total), 64'd1039);
    clear_q();

    // Back-to-back: 0-bit, 32-bit, flush with in_valid held
    send('0, 9'd0, 1'b0, 1'b1, a1);
    send({32'h12345678, 480'd0}, 9'd32, 1'b0, 1'b1, a2);
    send('0, 9'd0, 1'b1, 1'b0, a3);
    fd_exp++;
    wait_fd("b2b_fd", fd_exp);
    check("b2b_zero_one_cycle", 64'(a2 - a1), 64'd1);
    check("b2b_flush_accept", 64'(a3 - a2), 64'd2);
    check("b2b_count", 64'(wq.size()), 64'd1);
    if (wq.size() == 1) begin
      check("b2b_word", 64'(wq[0]), 64'h12345678);
      check("b2b_latency", 64'(cq[0]), 64'(a2 + 2));
    end
    check("b2b_fd_cycle", 64'(fd_cyc), 64'(a2 + 3));
    check("b2b_fd_no_word", 64'(fd_word), 64'd0);
    check("b2b_bit_total", 64'(bit_total), 64'd1071);
    clear_q();

    // Reset in the middle of draining a 501-bit block
    send({512{1'b1}}, 9'd501, 1'b0, 1'b0, a1);
    tick(4);
    reset = 1'b1;
    #1;
    check_reset_vals("mid_rst");
    tick(2);
    reset = 1'b0;
    clear_q();
    tick(30);
    check("mid_rst_no_stale", 64'(wq.size()), 64'd0);
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    send('0, 9'd0, 1'b1, 1'b0, a1);
    fd_exp++;
    wait_fd("mid_rst_fd", fd_exp);
    check("mid_rst_fd_no_word", 64'(fd_word), 64'd0);
    check("mid_rst_count", 64'(wq.size()), 64'd0);
    check("mid_rst_bit_total", 64'(bit_total), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
